// File: rtl/laser500_uart_pkg.sv
// laser500_uart_pkg: shared types and helpers for the Laser 500 serial transmitter
package laser500_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int FRAME_BITS = 10;
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/laser500_sync_fifo.sv
// laser500_sync_fifo: first-word fall-through byte FIFO with a sticky-overflow pulse
module laser500_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             ovf_pulse
);
    localparam int AW = $clog2(DEPTH);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of two >= 2");
    end
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic push, pop;
    assign full = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
    assign pop = rd && !empty;
    // a pop in the same cycle frees the slot, so a write while full still lands
    assign push = wr && (!full || pop);
    assign ovf_pulse = wr && full && !pop;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end
endmodule

// File: rtl/laser500_uart_tx.sv
// laser500_uart_tx: buffered 8N1 serial transmitter for the UART_TXD pin
module laser500_uart_tx
    import laser500_uart_pkg::*;
#(
    parameter int CLK_HZ = 14700000,
    parameter int BAUD = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr,
    input  logic       clr_ovf,
    output logic       txd,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int BW = $clog2(DIV);
    localparam logic [BW-1:0] RELOAD = BW'(DIV - 1);
    if (DIV < 2) begin : g_div_chk
        $error("baud divider must be >= 2");
    end
    tx_state_t state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n, fifo_dout;
    logic txd_n, pop, ovf_pulse, tick;
    laser500_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys(clk_sys),
        .reset(reset),
        .wr(wr),
        .din(din),
        .rd(pop),
        .dout(fifo_dout),
        .full(full),
        .empty(empty),
        .ovf_pulse(ovf_pulse)
    );
    assign busy = state != IDLE;
    assign tick = baud_cnt == '0;
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            baud_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            txd <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            baud_cnt <= baud_n;
            bit_cnt <= bit_cnt_n;
            shreg <= shreg_n;
            txd <= txd_n;
            overflow <= ovf_pulse ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    end
    always_comb begin
        state_n = state;
        bit_cnt_n = bit_cnt;
        shreg_n = shreg;
        txd_n = txd;
        pop = 1'b0;
        baud_n = busy ? baud_cnt - BW'(1) : baud_cnt;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (!empty) begin
                    pop = 1'b1;
                    shreg_n = fifo_dout;
                    txd_n = 1'b0;
                    baud_n = RELOAD;
                    state_n = START;
                end
            end
            START: if (tick) begin
                txd_n = shreg[0];
                bit_cnt_n = '0;
                baud_n = RELOAD;
                state_n = DATA;
            end
            DATA: if (tick) begin
                baud_n = RELOAD;
                if (bit_cnt == 3'd7) begin
                    txd_n = 1'b1;
                    state_n = STOP;
                end else begin
                    shreg_n = {1'b0, shreg[7:1]};
                    txd_n = shreg[1];
                    bit_cnt_n = bit_cnt + 3'd1;
                end
            end
            STOP: if (tick) begin
                // chain straight into the next start bit when more bytes wait
                if (!empty) begin
                    pop = 1'b1;
                    shreg_n = fifo_dout;
                    txd_n = 1'b0;
                    baud_n = RELOAD;
                    state_n = START;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_laser500_uart_tx.sv
// tb_laser500_uart_tx: directed checks of the buffered 8N1 transmitter
module tb_laser500_uart_tx;
    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic [7:0] din0 = '0, din1 = '0;
    logic wr0 = 1'b0, wr1 = 1'b0, clr0 = 1'b0;
    logic txd0, full0, empty0, busy0, ovf0;
    logic txd1, full1, empty1, busy1, ovf1;
    int pass_cnt = 0, tot_cnt = 0;
    logic [7:0] q [$];
    logic rec [15400];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs [6];

    always #5 clk_sys = ~clk_sys;

    laser500_uart_tx #(.CLK_HZ(40), .BAUD(10), .FIFO_DEPTH(16)) dut0 (
        .clk_sys(clk_sys), .reset(reset), .din(din0), .wr(wr0), .clr_ovf(clr0),
        .txd(txd0), .full(full0), .empty(empty0), .busy(busy0), .overflow(ovf0)
    );
    laser500_uart_tx dut1 (
        .clk_sys(clk_sys), .reset(reset), .din(din1), .wr(wr1), .clr_ovf(1'b0),
        .txd(txd1), .full(full1), .empty(empty1), .busy(busy1), .overflow(ovf1)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic put(input logic [7:0] b);
        din0 = b;
        wr0 = 1'b1;
        tick();
        wr0 = 1'b0;
    endtask

    task automatic check_frame(input logic [9:0] f);
        for (int c = 0; c < 40; c++) begin
            chk("frame_txd", txd0, f[c / 4]);
            chk("frame_busy", busy0, 1);
            tick();
        end
    endtask

    // independent receiver for the DIV=4 instance: samples mid-cell
    initial begin
        logic [7:0] b;
        forever begin
            tick();
            if (!reset && txd0 === 1'b0) begin
                repeat (2) tick();
                for (int k = 0; k < 8; k++) begin
                    repeat (4) tick();
                    b[k] = txd0;
                end
                repeat (4) tick();
                if (txd0 === 1'b1) q.push_back(b);
            end
        end
    end

    initial begin
        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h3C, 10'b1_00111100_0};
        vecs[2] = '{8'h81, 10'b1_10000001_0};
        vecs[3] = '{8'h55, 10'b1_01010101_0};
        vecs[4] = '{8'h6E, 10'b1_01101110_0};
        vecs[5] = '{8'h01, 10'b1_00000001_0};

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_full", full0, 0);
        chk("rst_ovf", ovf0, 0);
        for (int i = 0; i < 20; i++) begin
            chk("idle_txd", txd0, 1);
            chk("idle_busy", busy0, 0);
            chk("idle_empty", empty0, 1);
            tick();
        end

        for (int v = 0; v < 6; v++) begin
            put(vecs[v].data);
            chk("lat_empty", empty0, 0);
            chk("lat_busy", busy0, 0);
            chk("lat_txd", txd0, 1);
            tick();
            chk("pop_empty", empty0, 1);
            check_frame(vecs[v].frame);
            chk("done_busy", busy0, 0);
            chk("done_txd", txd0, 1);
            chk("rx_count", q.size(), 1);
            if (q.size() > 0) chk("rx_byte", q.pop_front(), vecs[v].data);
            repeat (3) tick();
        end

        put(8'h00);
        put(8'hFF);
        check_frame(10'b1_00000000_0);
        check_frame(10'b1_11111111_0);
        chk("b2b_busy", busy0, 0);
        chk("b2b_count", q.size(), 2);
        if (q.size() == 2) begin
            chk("b2b_rx0", q.pop_front(), 8'h00);
            chk("b2b_rx1", q.pop_front(), 8'hFF);
        end
        repeat (5) tick();

        for (int i = 1; i <= 17; i++) begin
            din0 = 8'(i);
            wr0 = 1'b1;
            tick();
        end
        wr0 = 1'b0;
        chk("ovf_full", full0, 1);
        chk("ovf_none", ovf0, 0);
        put(8'h12);
        chk("ovf_set", ovf0, 1);
        chk("ovf_full2", full0, 1);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        chk("ovf_clr", ovf0, 0);
        clr0 = 1'b1;
        put(8'h13);
        clr0 = 1'b0;
        chk("ovf_wins", ovf0, 1);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        chk("ovf_clr2", ovf0, 0);
        for (int w = 0; w < 900 && q.size() < 17; w++) tick();
        chk("drain_count", q.size(), 17);
        for (int i = 1; i <= 17 && q.size() > 0; i++) chk("drain_byte", q.pop_front(), i);
        repeat (60) tick();
        chk("drain_extra", q.size(), 0);
        chk("drain_busy", busy0, 0);
        chk("drain_empty", empty0, 1);

        put(8'h3C);
        put(8'h11);
        put(8'h22);
        put(8'h33);
        repeat (10) tick();
        chk("mid_busy", busy0, 1);
        chk("mid_empty", empty0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_txd", txd0, 1);
        chk("rst_empty", empty0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_full2", full0, 0);
        begin
            logic bad;
            bad = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (txd0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
                tick();
            end
            chk("rst_quiet", bad, 0);
        end
        q.delete();

        din1 = 8'h55;
        wr1 = 1'b1;
        tick();
        wr1 = 1'b0;
        begin
            int w, pos, len;
            logic v;
            logic [7:0] rx;
            w = 0;
            while (txd1 !== 1'b0 && w < 10) begin
                tick();
                w++;
            end
            chk("dflt_start", w < 10, 1);
            rec[0] = txd1;
            for (int i = 1; i < 15400; i++) begin
                tick();
                rec[i] = txd1;
            end
            pos = 0;
            for (int r = 0; r < 9; r++) begin
                len = 0;
                v = rec[pos];
                while (pos < 15400 && rec[pos] == v) begin
                    len++;
                    pos++;
                end
                chk("dflt_cell", len, 1531);
            end
            for (int k = 0; k < 8; k++) rx[k] = rec[int'((real'(k) + 1.5) * 14700000.0 / 9600.0)];
            chk("dflt_rx", rx, 8'h55);
            chk("dflt_stop", rec[int'(9.5 * 14700000.0 / 9600.0)], 1);
            chk("dflt_busy", busy1, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
